// File: rtl/dm_responder.sv
// dm_responder: single-port word memory that answers one request at a time
// with a fixed number of wait states before a one-cycle completion pulse.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low reset (clears FSM and storage)
//   req    in   1   initiator request, sampled only in IDLE
//   we     in   1   1 = write, 0 = read (captured with req)
//   addr   in  32   byte address (captured with req)
//   wdata  in  32   write data (captured with req)
//   be     in   4   byte enables for writes (captured with req)
//   ready  out  1   one-cycle completion pulse
//   rdata  out 32   read data, nonzero only during a read completion
//   err    out  1   access fault, only during a completion
//
// Optional feature: define DM_RESP_ERR_EN to fault misaligned or
// out-of-range accesses. Without it, addr[1:0] is ignored and the word
// index wraps modulo DEPTH_WORDS (DEPTH_WORDS must be a power of two).
module dm_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      word_off;
  logic [IDX_W-1:0] mem_idx;
  logic             fault;
  logic             wr_en;
  logic [31:0]      wr_word;

  // Offset is taken in 32-bit unsigned arithmetic, so addresses below
  // BASE_ADDR wrap to large indices rather than going negative.
  assign word_off = addr_q - BASE_ADDR;

`ifdef DM_RESP_ERR_EN
  logic [29:0] word_idx;
  logic        unused_bits;
  assign word_idx    = word_off[31:2];
  assign mem_idx     = word_idx[IDX_W-1:0];
  assign fault       = (addr_q[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
  assign unused_bits = ^word_off[1:0];
`else
  logic unused_bits;
  assign mem_idx     = word_off[IDX_W+1:2];
  assign fault       = 1'b0;
  assign unused_bits = ^{word_off[31:IDX_W+2], word_off[1:0]};
`endif

  // Next-state: capture only in IDLE, so later input changes are ignored
  // until the transaction has completed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from state so they are zero whenever not in RESP,
  // including immediately on reset. The write commits on the edge that
  // ends RESP, so a following read sees the new word.
  always_comb begin
    ready   = 1'b0;
    rdata   = '0;
    err     = 1'b0;
    wr_en   = 1'b0;
    wr_word = mem_q[mem_idx];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
    if (state_q == RESP) begin
      ready = 1'b1;
      err   = fault;
      if (!fault) begin
        if (we_q) wr_en = 1'b1;
        else      rdata = mem_q[mem_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured request fields are pure data; they are only consumed after
  // a capture in IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[mem_idx] <= wr_word;
    end
  end

endmodule
